// File: rtl/copro_serial_arbiter.sv
// Round-robin 2-way arbiter and bit-serial link master for the multiply coprocessor.
// One transaction at a time: request frame out on mosi, compute gap, result frame in on miso.
module copro_serial_arbiter #(
  parameter int unsigned TX_BITS    = 67,
  parameter int unsigned RX_BITS    = 32,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned RX_SKIP    = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [5:0]         req_opcode,
  input  logic [63:0]        req_opa,
  input  logic [63:0]        req_opb,
  output logic [1:0]         rsp_valid,
  output logic [RX_BITS-1:0] rsp_data,
  output logic               busy,
  output logic               nss,
  output logic               sclk,
  output logic               mosi,
  input  logic               miso
);

  localparam int unsigned RxLen  = RX_SKIP + RX_BITS;
  localparam int unsigned TxGap  = (TX_BITS > GAP_CYCLES) ? TX_BITS : GAP_CYCLES;
  localparam int unsigned CntMax = (TxGap > RxLen) ? TxGap : RxLen;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StTx, StGap, StRx, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [TX_BITS-1:0]   shreg_q, shreg_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic [RX_BITS-1:0]   result_q, result_d;
  logic [RX_BITS-1:0]   rsp_data_q, rsp_data_d;
  logic                 sel;

  // On a tie, favour whoever did not win last time.
  assign sel      = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
  assign rsp_data = rsp_data_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    rsp_data_d   = rsp_data_q;
    req_ready    = '0;
    rsp_valid    = '0;
    busy         = 1'b1;
    nss          = 1'b1;
    sclk         = 1'b0;
    mosi         = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (req_valid != 2'b00) begin
          req_ready[sel] = 1'b1;
          grant_d        = sel;
          shreg_d        = sel ? {req_opcode[5:3], req_opa[63:32], req_opb[63:32]}
                               : {req_opcode[2:0], req_opa[31:0], req_opb[31:0]};
          cnt_d          = '0;
          state_d        = StTx;
        end
      end
      StTx: begin
        nss     = 1'b0;
        sclk    = 1'b1;
        mosi    = shreg_q[TX_BITS-1];
        shreg_d = shreg_q << 1;
        if (cnt_q == CntW'(TX_BITS - 1)) begin
          cnt_d   = '0;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StRx;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRx: begin
        nss   = 1'b0;
        cnt_d = cnt_q + CntW'(1);
        // The slave needs RX_SKIP cycles before its first result bit is valid.
        if (cnt_q >= CntW'(RX_SKIP)) begin
          sclk     = 1'b1;
          result_d = {result_q[RX_BITS-2:0], miso};
        end
        if (cnt_q == CntW'(RxLen - 1)) begin
          rsp_data_d = {result_q[RX_BITS-2:0], miso};
          cnt_d      = '0;
          state_d    = StDone;
        end
      end
      StDone: begin
        rsp_valid[grant_q] = 1'b1;
        last_grant_d       = grant_q;
        state_d            = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shreg_q      <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_copro_serial_arbiter.sv
// Scoreboard bench for copro_serial_arbiter: expected handshakes, frames and responses are
// queued by the stimulus and checked by independent monitors plus a serial slave model.
module tb_copro_serial_arbiter;

  localparam int TxBits    = 67;
  localparam int GapCycles = 4;
  localparam int RxCycles  = 33;
  localparam int Latency   = 105;
  localparam int Spacing   = 106;

  typedef struct packed {
    logic [1:0]  ready;
    logic [66:0] frame;
  } hs_t;

  typedef struct packed {
    logic [1:0]  valid;
    logic [31:0] data;
  } rsp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [5:0]  req_opcode = '0;
  logic [63:0] req_opa = '0;
  logic [63:0] req_opb = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        busy, nss, sclk, mosi;
  logic        miso = 1'b0;

  always #5 clock = ~clock;

  copro_serial_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_opa    (req_opa),
    .req_opb    (req_opb),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .nss        (nss),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  hs_t         hs_q[$];
  rsp_t        rsp_q[$];
  logic [66:0] frame_q[$];
  int          lat_q[$];
  int          hs_hist[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [66:0] mk(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    return {op, a, b};
  endfunction

  // Slave-side compute model; one pattern returns a marker instead of a product.
  function automatic logic [31:0] slave_result(input logic [66:0] f);
    logic [31:0] a, b;
    a = f[63:32];
    b = f[31:0];
    if (a == 32'h8000_0001 && b == 32'h0) return 32'hA5A5_0F0F;
    return a * b;
  endfunction

  // Handshake monitor
  hs_t hs_e;
  initial forever begin
    @(negedge clock);
    if (reset && req_ready != 2'b00) begin
      if (hs_q.size() == 0) begin
        chk("unexpected_ready", {94'h0, req_ready}, 96'h0);
      end else begin
        hs_e = hs_q.pop_front();
        chk("grant", {94'h0, req_ready}, {94'h0, hs_e.ready});
        frame_q.push_back(hs_e.frame);
        lat_q.push_back(cyc);
        hs_hist.push_back(cyc);
      end
    end
  end

  // Response monitor
  rsp_t rsp_e;
  int   t0;
  initial forever begin
    @(negedge clock);
    if (reset && rsp_valid != 2'b00) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_rsp", {94'h0, rsp_valid}, 96'h0);
      end else begin
        rsp_e = rsp_q.pop_front();
        chk("rsp_valid", {94'h0, rsp_valid}, {94'h0, rsp_e.valid});
        chk("rsp_data", {64'h0, rsp_data}, {64'h0, rsp_e.data});
        if (lat_q.size() == 0) begin
          chk("rsp_without_handshake", 96'h1, 96'h0);
        end else begin
          t0 = lat_q.pop_front();
          chk("latency", 96'(cyc - t0), 96'(Latency));
        end
      end
    end
  end

  // Serial slave model
  logic        s_rx, s_prev_nss;
  int          s_bits, s_rcyc, s_rclk, s_gap;
  logic [66:0] s_frame, s_last_frame, s_exp;
  logic [31:0] s_rsp;
  initial begin
    s_rx = 1'b0; s_prev_nss = 1'b1; s_bits = 0; s_rcyc = 0; s_rclk = 0; s_gap = 0;
    s_frame = '0; s_last_frame = '0; s_rsp = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        s_rx = 1'b0; s_prev_nss = 1'b1; s_bits = 0; s_rcyc = 0; s_rclk = 0; s_gap = 0;
        miso = 1'b0;
      end else begin
        if (!nss) begin
          if (s_prev_nss && s_rx) begin
            chk("gap_cycles", 96'(s_gap), 96'(GapCycles));
            s_rcyc = 0;
            s_rclk = 0;
          end
          if (s_prev_nss && !s_rx) begin
            s_bits  = 0;
            s_frame = '0;
          end
          if (!s_rx) begin
            if (sclk) begin
              s_frame = {s_frame[65:0], mosi};
              s_bits++;
            end
          end else begin
            s_rcyc++;
            if (sclk && s_rclk < 32) begin
              miso = s_rsp[31 - s_rclk];
              s_rclk++;
            end else begin
              miso = 1'b0;
            end
          end
        end else begin
          miso = 1'b0;
          if (!s_prev_nss && !s_rx) begin
            chk("tx_bits", 96'(s_bits), 96'(TxBits));
            if (frame_q.size() == 0) begin
              chk("unexpected_frame", 96'h1, 96'h0);
            end else begin
              s_exp = frame_q.pop_front();
              chk("tx_frame", {29'h0, s_frame}, {29'h0, s_exp});
            end
            s_last_frame = s_frame;
            s_rsp        = slave_result(s_frame);
            s_rx         = 1'b1;
            s_gap        = 1;
          end else if (!s_prev_nss && s_rx) begin
            chk("rx_cycles", 96'(s_rcyc), 96'(RxCycles));
            chk("rx_sclk_cycles", 96'(s_rclk), 96'd32);
            s_rx = 1'b0;
          end else if (s_rx) begin
            s_gap++;
          end
        end
        s_prev_nss = nss;
      end
    end
  end

  task automatic set_req(input int idx, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_opcode[idx*3 +: 3] = op;
    req_opa[idx*32 +: 32]  = a;
    req_opb[idx*32 +: 32]  = b;
  endtask

  task automatic expect_hs(input logic [1:0] ready, input logic [66:0] frame);
    hs_t e;
    e.ready = ready;
    e.frame = frame;
    hs_q.push_back(e);
  endtask

  task automatic expect_rsp(input logic [1:0] valid, input logic [31:0] data);
    rsp_t e;
    e.valid = valid;
    e.data  = data;
    rsp_q.push_back(e);
  endtask

  // Returns just after the posedge on which the handshake completed.
  task automatic wait_ready(input int idx, input int budget);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!req_ready[idx] && n < budget);
    chk("ready_within_budget", {95'h0, req_ready[idx]}, 96'h1);
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while ((busy || rsp_q.size() != 0) && n < budget);
    chk({name, "_idle"}, {94'h0, busy, rsp_q.size() == 0}, 96'h1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic chk_spacing(input string name);
    int n;
    n = hs_hist.size();
    if (n < 2) chk({name, "_hs_count"}, 96'(n), 96'd2);
    else chk(name, 96'(hs_hist[n-1] - hs_hist[n-2]), 96'(Spacing));
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_nss", {95'h0, nss}, 96'h1);
    chk("reset_sclk", {95'h0, sclk}, 96'h0);
    chk("reset_mosi", {95'h0, mosi}, 96'h0);
    chk("reset_busy", {95'h0, busy}, 96'h0);
    chk("reset_rsp_valid", {94'h0, rsp_valid}, 96'h0);
    chk("reset_rsp_data", {64'h0, rsp_data}, 96'h0);
    chk("reset_req_ready", {94'h0, req_ready}, 96'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Single req0: 3 * 5
    set_req(0, 3'b000, 32'd3, 32'd5);
    expect_hs(2'b01, mk(3'b000, 32'd3, 32'd5));
    expect_rsp(2'b01, 32'd15);
    req_valid = 2'b01;
    wait_ready(0, 1);
    req_valid = 2'b00;
    wait_idle("single", 300);

    // Tie after reset goes to req0, then req1 right after req0's DONE
    do_reset();
    set_req(0, 3'b000, 32'd3, 32'd5);
    set_req(1, 3'b010, 32'd7, 32'd6);
    expect_hs(2'b01, mk(3'b000, 32'd3, 32'd5));
    expect_hs(2'b10, mk(3'b010, 32'd7, 32'd6));
    expect_rsp(2'b01, 32'd15);
    expect_rsp(2'b10, 32'd42);
    req_valid = 2'b11;
    wait_ready(0, 2);
    req_valid[0] = 1'b0;
    wait_ready(1, 300);
    req_valid[1] = 1'b0;
    chk_spacing("tie_spacing");
    wait_idle("tie", 300);
    chk("rsp_data_hold", {64'h0, rsp_data}, 96'd42);

    // Both continuously valid: grants alternate 0,1,0,1
    set_req(0, 3'b001, 32'd2, 32'd9);
    for (int i = 0; i < 2; i++) begin
      expect_hs(2'b01, mk(3'b001, 32'd2, 32'd9));
      expect_hs(2'b10, mk(3'b010, 32'd7, 32'd6));
      expect_rsp(2'b01, 32'd18);
      expect_rsp(2'b10, 32'd42);
    end
    req_valid = 2'b11;
    for (int n = 0; n < 600 && hs_q.size() != 0; n++) begin
      @(posedge clock);
      #1;
    end
    req_valid = 2'b00;
    chk("alt_all_granted", 96'(hs_q.size()), 96'h0);
    chk_spacing("alt_spacing");
    wait_idle("alt", 300);

    // MSB-first framing and RX skip
    set_req(0, 3'b101, 32'h8000_0001, 32'h0);
    expect_hs(2'b01, mk(3'b101, 32'h8000_0001, 32'h0));
    expect_rsp(2'b01, 32'hA5A5_0F0F);
    req_valid = 2'b01;
    wait_ready(0, 2);
    req_valid = 2'b00;
    wait_idle("msb", 300);
    chk("mosi_bit3", {95'h0, s_last_frame[63]}, 96'h1);
    chk("mosi_bit34", {95'h0, s_last_frame[32]}, 96'h1);

    // Reset during TX bit 20 aborts with no response
    set_req(0, 3'b011, 32'd11, 32'd13);
    expect_hs(2'b01, mk(3'b011, 32'd11, 32'd13));
    req_valid = 2'b01;
    wait_ready(0, 2);
    req_valid = 2'b00;
    repeat (20) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    frame_q.delete();
    lat_q.delete();
    @(negedge clock);
    chk("abort_nss", {95'h0, nss}, 96'h1);
    chk("abort_busy", {95'h0, busy}, 96'h0);
    repeat (150) @(posedge clock);
    #1;
    expect_hs(2'b01, mk(3'b011, 32'd11, 32'd13));
    expect_rsp(2'b01, 32'd143);
    req_valid = 2'b01;
    wait_ready(0, 2);
    req_valid = 2'b00;
    wait_idle("after_abort", 300);

    // Short req0 pulse while busy is dropped
    set_req(1, 3'b110, 32'd4, 32'd4);
    expect_hs(2'b10, mk(3'b110, 32'd4, 32'd4));
    expect_rsp(2'b10, 32'd16);
    req_valid = 2'b10;
    wait_ready(1, 2);
    req_valid = 2'b00;
    repeat (5) @(posedge clock);
    #1;
    set_req(0, 3'b111, 32'd9, 32'd9);
    req_valid = 2'b01;
    @(posedge clock);
    #1;
    req_valid = 2'b00;
    wait_idle("pulse", 300);
    repeat (20) @(posedge clock);
    #1;
    chk("pulse_idle_busy", {95'h0, busy}, 96'h0);

    chk("hs_q_empty", 96'(hs_q.size()), 96'h0);
    chk("rsp_q_empty", 96'(rsp_q.size()), 96'h0);
    chk("frame_q_empty", 96'(frame_q.size()), 96'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/copro_serial_arbiter.md
Name: copro_serial_arbiter

Overview:
- Serial-link master and 2-way arbiter for the bit-serial multiply coprocessor.
- Accepts parallel requests (opcode, opa, opb) from two requesters and selects one round-robin.
- Serialises the selected request onto nss/sclk/mosi, waits out the coprocessor compute gap, then clocks the 32-bit result back over miso.
- Returns the result to the requester that issued it. Sits between the core's execute stage / DMA port and the coprocessor pins.

Parameters:
- TX_BITS, 67, request frame length: opcode[2:0], then opa[31:0], then opb[31:0], MSB first.
- RX_BITS, 32, result frame length, MSB first.
- GAP_CYCLES, 4, cycles nss is held high between the request and response frames (coprocessor compute time); legal range ≥ 1.
- RX_SKIP, 1, cycles at the start of the response frame in which miso is not sampled (slave output latency); legal range ≥ 0.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  2  per-requester request valid; must be held until the matching req_ready
- req_ready  out  2  one-hot accept strobe, combinational, asserted only in IDLE
- req_opcode  in  6  {req1[5:3], req0[2:0]}
- req_opa  in  64  {req1[63:32], req0[31:0]}
- req_opb  in  64  {req1[63:32], req0[31:0]}
- rsp_valid  out  2  one-cycle result strobe to the issuing requester
- rsp_data  out  32  result; valid while rsp_valid is nonzero, held until the next DONE
- busy  out  1  high in every state except IDLE
- nss  out  1  active-low frame select
- sclk  out  1  bit strobe; high in every cycle in which a bit is driven or sampled
- mosi  out  1  serial request data
- miso  in  1  serial result data

Behaviour:
- Reset (reset=0 at a clock edge) forces the following values:
  - state=IDLE, nss=1, sclk=0, mosi=0, rsp_valid=0, rsp_data=0.
  - last_grant=1, so req0 wins the first tie.
  - A reset during any state aborts the transaction. nss=1 from the next cycle; no rsp_valid is issued for the aborted request.
- States: IDLE → TX → GAP → RX → DONE → IDLE.
- IDLE:
  - nss=1, sclk=0.
  - If exactly one req_valid bit is set, grant that requester.
  - If both are set, grant the requester ≠ last_grant.
  - req_ready[g]=1 in the same cycle. On that edge, latch shreg={opcode_g, opa_g, opb_g} and g, then go to TX.
  - req_ready=0 in all other states.
- TX: runs exactly TX_BITS cycles.
  - nss=0, sclk=1, mosi=shreg[66]; shreg shifts left by 1 per cycle.
  - Bit k (k=0..66) of the frame appears in the k-th TX cycle.
  - After the last bit, go to GAP.
- GAP: runs exactly GAP_CYCLES cycles. nss=1, sclk=0, mosi=0.
- RX: runs RX_SKIP+RX_BITS cycles.
  - nss=0 throughout.
  - sclk=0 in the first RX_SKIP cycles, sclk=1 in the rest.
  - During the sclk=1 cycles, sample miso into the result register by shifting left (result={result[30:0], miso}), so the first sampled bit ends in bit 31.
- DONE: one cycle.
  - nss=1, rsp_valid[g]=1, rsp_data=assembled result, last_grant<=g, then go to IDLE.
  - rsp_valid returns to 0 the next cycle; rsp_data holds its value.
- Latency: handshake in cycle T → rsp_valid in cycle T+1+TX_BITS+GAP_CYCLES+RX_SKIP+RX_BITS. With defaults this is T+105.
- Throughput: one transaction at a time; the minimum request-to-request spacing is 106 cycles with defaults.
- A new request cannot be accepted in the DONE cycle, only in the following IDLE cycle.
- A req_valid that drops before ready is ignored with no side effects. Requests arriving while busy wait, and are not lost if the requester keeps them asserted.
- The opcode is passed through unmodified; the arbiter does not interpret it.

Test Plan:
- After reset, only req0 requests: opcode=3'b000, opa=3, opb=5, slave model returns 32'd15.
  - req_ready=2'b01 in the same cycle.
  - nss low for 67 cycles, with mosi sequence 000, then 3 as 32 bits, then 5 as 32 bits.
  - nss high for 4 cycles.
  - rsp_valid=2'b01 and rsp_data=15 at T+105.
- req0 and req1 both valid in the first IDLE after reset: req0 is granted first.
  - req1 (opa=7, opb=6, model returns 42) is granted in the IDLE cycle right after req0's DONE.
  - req1 gets rsp_valid=2'b10 with data 42.
- req0 re-requests immediately after each response while req1 is continuously valid: grants alternate 0,1,0,1 over 4 transactions.
- MSB-first check: opa=32'h8000_0001, opb=0, model returns 32'hA5A5_0F0F.
  - mosi bit 3 = 1 and bit 34 = 1.
  - rsp_data=32'hA5A5_0F0F, confirming that miso sampling skips the first RX cycle.
- reset=0 during TX bit 20:
  - nss=1 and busy=0 from the next cycle; no rsp_valid.
  - A subsequent request produces a full fresh 67-bit frame and a correct result.
- req0 valid for 1 cycle while busy, then deasserted: it is never granted, never gets rsp_valid, and the engine returns to IDLE.
